// File: rtl/enc_8x3_req.sv
// 8-to-3 request encoder with a pending register and a valid/ready hold stage.
// Define ENC_ROUND_ROBIN_EN for rotating priority; the default build uses fixed highest-index-wins priority.
//
// state | meaning
// IDLE  | nothing held; a grant is loaded from pend when any bit is set
// HOLD  | out_code/out_multi held and valid until accepted or flushed
module enc_8x3_req (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] req,
  input  logic       flush,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [0:2] out_code,
  output logic       out_multi,
  output logic [0:7] pend
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q;
  logic [0:7] pend_q;
  logic [0:7] pend_d;
  logic [0:7] clr_mask;
  logic [2:0] code_q;
  logic       multi_q;
  logic [2:0] sel;
  logic [3:0] pend_cnt;
  logic       accept;

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] idx;
`endif

  assign accept = (state_q == HOLD) && out_ready;

  always_comb begin
    pend_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pend_cnt = pend_cnt + {3'b000, pend_q[i]};
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  // Scan from lowest to highest priority so the last hit (at ptr_q) wins.
  always_comb begin
    sel = 3'd0;
    idx = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      idx = ptr_q - 3'(j);
      if (pend_q[idx]) sel = idx;
    end
  end
`else
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end
`endif

  // A new request on the granted line in the accept cycle survives the clear.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[code_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= 3'd0;
      multi_q <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr_q   <= 3'd7;
`endif
    end else if (flush) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= 3'd0;
      multi_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            state_q <= HOLD;
            code_q  <= sel;
            multi_q <= (pend_cnt >= 4'd2);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= IDLE;
`ifdef ENC_ROUND_ROBIN_EN
            ptr_q   <= code_q - 3'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_code  = code_q;
  assign out_multi = multi_q;
  assign pend      = pend_q;

endmodule
